wb_openram_arbiter: RTL and testbench
=====================================

Name: wb_openram_arbiter

Overview:
- Shares one OpenRAM RW port (port 0) between two Wishbone slave ports.
- Port A is the Caravel management Wishbone. Port B is a user-area master, e.g. DMA or accelerator.
- Provides registered RAM command timing, round-robin arbitration and one-cycle acks.
- Replaces direct single-master RAM glue when a second master needs the same SRAM macro.

Parameters:
- BASE_ADDR, 32'h30c0_0000: byte base of the RAM window, shared by both ports.
- ADDR_WIDTH, 8: RAM word-address width; window size = 4 << ADDR_WIDTH bytes.

Ports:
- wb_clk_i  in  1  single clock; RAM clocks also driven from it
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_a_cyc_i / wbs_a_stb_i / wbs_a_we_i  in  1 each  port A Wishbone controls
- wbs_a_sel_i  in  4  port A byte selects
- wbs_a_adr_i / wbs_a_dat_i  in  32 each  port A address, write data
- wbs_a_ack_o  out  1  port A ack
- wbs_a_dat_o  out  32  port A read data
- wbs_b_*  same set as A  port B
- ram_clk0  out  1  = wb_clk_i
- ram_csb0  out  1  active-low chip select
- ram_web0  out  1  active-low write enable
- ram_wmask0  out  4  byte write mask
- ram_addr0  out  ADDR_WIDTH  word address
- ram_dout0  out  32  write data to RAM
- ram_din0  in  32  read data from RAM
- ram_clk1, ram_csb1, ram_addr1  out  1/1/ADDR_WIDTH  port 1 tie-off: clk = wb_clk_i, csb = 1, addr = 0

Behaviour:
- Hit, per port: cyc & stb & ((adr & ~(4<<ADDR_WIDTH)-1) == BASE_ADDR). Non-hits are ignored and never acked; another slave owns them.
- Word address = adr[ADDR_WIDTH+1:2]. adr[1:0] is ignored.
- FSM states: IDLE, CMD, CAPT, ACK. All state and outputs are registered on posedge wb_clk_i.
- IDLE:
  - If any hit, select winner; latch winner id, addr, we, sel, wdata; go to CMD.
  - No hit: stay.
- CMD (one cycle):
  - csb0 = 0, web0 = ~we_l, addr0 = addr_l, dout0 = wdata_l.
  - wmask0 = sel_l if write, 4'b0000 if read.
  - RAM samples at the end of this cycle. Go to CAPT.
- CAPT (one cycle):
  - csb0 = 1. Read data is captured from ram_din0 into rdata_r at end of cycle; writes capture nothing.
  - Go to ACK.
- ACK (one cycle):
  - Winner's ack_o = 1 only if its cyc & stb are still high. Winner's dat_o = rdata_r (0 after a write).
  - Go to IDLE.
- Latency: request visible in cycle 0 → ack in cycle 3. Back-to-back grants are possible from cycle 4.
- Arbitration:
  - Round-robin via last_grant register.
  - Both hit in IDLE → grant the port != last_grant. Single hit → grant it.
  - last_grant updates on every grant.
  - last_grant resets to B, so A wins the first tie.
- Loser stalls (no ack) until it is granted. A continuously requesting master cannot starve the other: grants alternate under contention.
- Master abort: if the winner drops cyc/stb after CMD, the RAM access still completes (writes land) and the ack is suppressed. FSM returns to IDLE on the normal schedule.
- Idle outputs: csb0 = 1, web0 = 1, wmask0 = 0, addr0/dout0 hold the last latched values.
- ack_o is never high in two consecutive cycles. dat_o holds rdata_r between acks.
- Async reset (wb_rst_ni = 0), including mid-operation:
  - state = IDLE, csb0 = 1, web0 = 1, wmask0 = 0, both ack_o = 0, both dat_o = 0, addr0 = 0, dout0 = 0, rdata_r = 0, last_grant = B.
  - Any in-flight access is dropped without ack.
  - Release is synchronised: the FSM leaves IDLE no earlier than the second posedge after deassertion.

Test Plan:
- A write 0xDEADBEEF to 0x30c0_0010, sel = 4'hF; then A read 0x30c0_0010 → csb0 low one cycle with addr0 = 4, wmask0 = F, web0 = 0. Read ack in cycle 3 with dat_o = 0xDEADBEEF.
- B write sel = 4'b0011, data 0x1234_5678, over a word holding 0xAAAA_AAAA; then B read → 0xAAAA_5678, wmask0 = 4'b0011 during the write CMD.
- A and B both request in the same cycle, first time after reset → A served first (ack cycle 3), B acked in cycle 7. Repeat the tie → B first this time.
- A holds back-to-back requests while B requests once → B granted at the next IDLE after A's current access. B's ack arrives within 8 cycles of its request.
- A requests 0x3100_0000 (outside window) → no csb0 activity, no ack. A write that drops stb in CAPT → memory updated, no ack, FSM back in IDLE at cycle 4.
- Assert wb_rst_ni low asynchronously during CMD → all outputs go to reset values immediately. After release, a pending B request completes normally.

Source files
------------

// File: rtl/wb_openram_arbiter.sv
// Two-port Wishbone front end for a single OpenRAM RW port: round-robin
// arbitration, registered RAM command timing and a single-cycle ack per access.
module wb_openram_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h30c0_0000,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_a_cyc_i,
  input  logic                  wbs_a_stb_i,
  input  logic                  wbs_a_we_i,
  input  logic [3:0]            wbs_a_sel_i,
  input  logic [31:0]           wbs_a_adr_i,
  input  logic [31:0]           wbs_a_dat_i,
  output logic                  wbs_a_ack_o,
  output logic [31:0]           wbs_a_dat_o,
  input  logic                  wbs_b_cyc_i,
  input  logic                  wbs_b_stb_i,
  input  logic                  wbs_b_we_i,
  input  logic [3:0]            wbs_b_sel_i,
  input  logic [31:0]           wbs_b_adr_i,
  input  logic [31:0]           wbs_b_dat_i,
  output logic                  wbs_b_ack_o,
  output logic [31:0]           wbs_b_dat_o,
  output logic                  ram_clk0,
  output logic                  ram_csb0,
  output logic                  ram_web0,
  output logic [3:0]            ram_wmask0,
  output logic [ADDR_WIDTH-1:0] ram_addr0,
  output logic [31:0]           ram_dout0,
  input  logic [31:0]           ram_din0,
  output logic                  ram_clk1,
  output logic                  ram_csb1,
  output logic [ADDR_WIDTH-1:0] ram_addr1
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_CAPT, S_ACK} state_e;

  localparam logic [31:0] WIN_MASK = ~((32'd4 << ADDR_WIDTH) - 32'd1);

  state_e                  state_q, state_d;
  logic [1:0]              rst_sync_q, rst_sync_d;
  logic                    last_grant_q, last_grant_d;  // 1 = port B
  logic                    winner_q, winner_d;
  logic                    we_q, we_d;
  logic                    csb0_q, csb0_d;
  logic                    web0_q, web0_d;
  logic [3:0]              wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0]   addr0_q, addr0_d;
  logic [31:0]             dout0_q, dout0_d;
  logic                    a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [31:0]             a_dat_q, a_dat_d, b_dat_q, b_dat_d;

  logic        a_hit, b_hit, grant_b;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_adr, req_dat, capt_data;

  assign a_hit = wbs_a_cyc_i & wbs_a_stb_i & ((wbs_a_adr_i & WIN_MASK) == BASE_ADDR);
  assign b_hit = wbs_b_cyc_i & wbs_b_stb_i & ((wbs_b_adr_i & WIN_MASK) == BASE_ADDR);

  // On a tie the port that did not win last time gets the RAM.
  assign grant_b = b_hit & (~a_hit | ~last_grant_q);

  assign req_we    = grant_b ? wbs_b_we_i  : wbs_a_we_i;
  assign req_sel   = grant_b ? wbs_b_sel_i : wbs_a_sel_i;
  assign req_adr   = grant_b ? wbs_b_adr_i : wbs_a_adr_i;
  assign req_dat   = grant_b ? wbs_b_dat_i : wbs_a_dat_i;
  assign capt_data = we_q ? 32'h0 : ram_din0;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    rst_sync_d   = {rst_sync_q[0], 1'b1};
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    we_d         = we_q;
    csb0_d       = csb0_q;
    web0_d       = web0_q;
    wmask0_d     = wmask0_q;
    addr0_d      = addr0_q;
    dout0_d      = dout0_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_dat_d      = a_dat_q;
    b_dat_d      = b_dat_q;

    unique case (state_q)
      S_IDLE: begin
        if (rst_sync_q[1] && (a_hit || b_hit)) begin
          winner_d     = grant_b;
          last_grant_d = grant_b;
          we_d         = req_we;
          csb0_d       = 1'b0;
          web0_d       = ~req_we;
          wmask0_d     = req_we ? req_sel : 4'b0000;
          addr0_d      = req_adr[ADDR_WIDTH+1:2];
          dout0_d      = req_dat;
          state_d      = S_CMD;
        end
      end
      S_CMD: begin
        csb0_d   = 1'b1;
        web0_d   = 1'b1;
        wmask0_d = 4'b0000;
        state_d  = S_CAPT;
      end
      S_CAPT: begin
        // A master that has let go by now still gets its write, but no ack.
        if (winner_q) begin
          b_dat_d = capt_data;
          b_ack_d = wbs_b_cyc_i & wbs_b_stb_i;
        end else begin
          a_dat_d = capt_data;
          a_ack_d = wbs_a_cyc_i & wbs_a_stb_i;
        end
        state_d = S_ACK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Leaving IDLE is gated by a two-stage synchroniser on reset release.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= S_IDLE;
      rst_sync_q   <= 2'b00;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      we_q         <= 1'b0;
      csb0_q       <= 1'b1;
      web0_q       <= 1'b1;
      wmask0_q     <= 4'b0000;
      addr0_q      <= '0;
      dout0_q      <= 32'h0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_dat_q      <= 32'h0;
      b_dat_q      <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, independent of statement order.
      state_q      <= state_d;
      rst_sync_q   <= rst_sync_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      we_q         <= we_d;
      csb0_q       <= csb0_d;
      web0_q       <= web0_d;
      wmask0_q     <= wmask0_d;
      addr0_q      <= addr0_d;
      dout0_q      <= dout0_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_dat_q      <= a_dat_d;
      b_dat_q      <= b_dat_d;
    end
  end

  assign wbs_a_ack_o = a_ack_q;
  assign wbs_a_dat_o = a_dat_q;
  assign wbs_b_ack_o = b_ack_q;
  assign wbs_b_dat_o = b_dat_q;

  assign ram_clk0   = wb_clk_i;
  assign ram_csb0   = csb0_q;
  assign ram_web0   = web0_q;
  assign ram_wmask0 = wmask0_q;
  assign ram_addr0  = addr0_q;
  assign ram_dout0  = dout0_q;

  assign ram_clk1  = wb_clk_i;
  assign ram_csb1  = 1'b1;
  assign ram_addr1 = '0;

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// Bench for wb_openram_arbiter: a behavioural SRAM macro, a word-array model of
// memory contents, and a per-port queue of expected read data popped on each ack.
module tb_wb_openram_arbiter;

  localparam logic [31:0] BASE = 32'h30c0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [3:0]  a_sel, b_sel;
  logic [31:0] a_adr, a_wdat, b_adr, b_wdat;
  logic        a_ack, b_ack;
  logic [31:0] a_rdat, b_rdat;
  logic        ram_clk0, ram_csb0, ram_web0, ram_clk1, ram_csb1;
  logic [3:0]  ram_wmask0;
  logic [7:0]  ram_addr0, ram_addr1;
  logic [31:0] ram_dout0, ram_din0;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int csb_low_cnt = 0;
  logic [7:0]  last_addr;
  logic [3:0]  last_wmask;
  logic        last_web;
  logic [31:0] last_dout;

  logic [31:0] ram   [256];
  logic [31:0] model [256];
  logic        ram_fill = 1'b1;
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];

  wb_openram_arbiter #(.BASE_ADDR(BASE), .ADDR_WIDTH(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_a_cyc_i(a_cyc), .wbs_a_stb_i(a_stb), .wbs_a_we_i(a_we), .wbs_a_sel_i(a_sel),
    .wbs_a_adr_i(a_adr), .wbs_a_dat_i(a_wdat), .wbs_a_ack_o(a_ack), .wbs_a_dat_o(a_rdat),
    .wbs_b_cyc_i(b_cyc), .wbs_b_stb_i(b_stb), .wbs_b_we_i(b_we), .wbs_b_sel_i(b_sel),
    .wbs_b_adr_i(b_adr), .wbs_b_dat_i(b_wdat), .wbs_b_ack_o(b_ack), .wbs_b_dat_o(b_rdat),
    .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0), .ram_wmask0(ram_wmask0),
    .ram_addr0(ram_addr0), .ram_dout0(ram_dout0), .ram_din0(ram_din0),
    .ram_clk1(ram_clk1), .ram_csb1(ram_csb1), .ram_addr1(ram_addr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] fill_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  // SRAM macro: synchronous write with byte mask, read data after the edge.
  always @(posedge ram_clk0) begin
    if (ram_fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= fill_word(i);
    end else if (!ram_csb0) begin
      if (!ram_web0) begin
        for (int i = 0; i < 4; i++)
          if (ram_wmask0[i]) ram[ram_addr0][8*i +: 8] <= ram_dout0[8*i +: 8];
      end else begin
        ram_din0 <= ram[ram_addr0];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc_cnt);
    end
  endtask

  // Monitor: pops the expected read data whenever a port acks.
  initial begin
    logic prev_a, prev_b;
    prev_a = 1'b0;
    prev_b = 1'b0;
    forever begin
      @(negedge clk);
      if (!ram_csb0) begin
        csb_low_cnt++;
        last_addr  = ram_addr0;
        last_wmask = ram_wmask0;
        last_web   = ram_web0;
        last_dout  = ram_dout0;
      end
      if (a_ack) begin
        if (exp_a.size() == 0) check("a_unexpected_ack", 1, 0);
        else check("a_rdata", a_rdat, exp_a.pop_front());
      end
      if (b_ack) begin
        if (exp_b.size() == 0) check("b_unexpected_ack", 1, 0);
        else check("b_rdata", b_rdat, exp_b.pop_front());
      end
      if (a_ack && prev_a) check("a_ack_consecutive", 1, 0);
      if (b_ack && prev_b) check("b_ack_consecutive", 1, 0);
      prev_a = a_ack;
      prev_b = b_ack;
    end
  end

  // One Wishbone access on port p (0 = A, 1 = B); called at posedge+1, returns
  // at posedge+1 with the request dropped. lat = cycles from request to ack.
  task automatic xfer(input bit p, input bit we, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [3:0] sel, output int lat);
    logic [31:0] want;
    int word, start;
    word = int'(adr[9:2]);
    if (we) begin
      want = 32'h0;
      for (int i = 0; i < 4; i++)
        if (sel[i]) model[word][8*i +: 8] = wd[8*i +: 8];
    end else begin
      want = model[word];
    end
    if (!p) begin
      exp_a.push_back(want);
      a_we = we; a_sel = sel; a_adr = adr; a_wdat = wd; a_cyc = 1'b1; a_stb = 1'b1;
    end else begin
      exp_b.push_back(want);
      b_we = we; b_sel = sel; b_adr = adr; b_wdat = wd; b_cyc = 1'b1; b_stb = 1'b1;
    end
    start = cyc_cnt;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((!p && a_ack) || (p && b_ack)) begin
        lat = cyc_cnt - start;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!p) begin a_cyc = 1'b0; a_stb = 1'b0; end
    else    begin b_cyc = 1'b0; b_stb = 1'b0; end
    check(p ? "b_ack_seen" : "a_ack_seen", 32'(lat >= 0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_a1, lat_a2, lat_a3, lat_b, c0;
    logic [31:0] oow_adr [4];
    a_cyc = 0; a_stb = 0; a_we = 0; a_sel = 0; a_adr = 0; a_wdat = 0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_sel = 0; b_adr = 0; b_wdat = 0;
    for (int i = 0; i < 256; i++) model[i] = fill_word(i);

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 ram_fill = 1'b0;
    check("rst_csb0", ram_csb0, 1);
    check("rst_web0", ram_web0, 1);
    check("rst_wmask0", ram_wmask0, 0);
    check("rst_addr0", ram_addr0, 0);
    check("rst_dout0", ram_dout0, 0);
    check("rst_acks", {a_ack, b_ack}, 0);
    check("rst_dat", a_rdat | b_rdat, 0);
    check("tie_csb1", ram_csb1, 1);
    check("tie_addr1", ram_addr1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // First tie after reset goes to A; A re-requests at once and ties again -> B.
    fork
      begin
        xfer(0, 0, BASE + 32'h10, 32'h0, 4'h0, lat_a1);
        xfer(0, 0, BASE + 32'h14, 32'h0, 4'h0, lat_a2);
      end
      xfer(1, 0, BASE + 32'h200, 32'h0, 4'h0, lat_b);
    join
    check("tie1_a_lat", lat_a1, 3);
    check("tie1_b_lat", lat_b, 7);
    check("tie2_a_lat", lat_a2, 7);

    // A write then read, with the RAM command observed.
    c0 = csb_low_cnt;
    xfer(0, 1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, lat);
    check("a_wr_lat", lat, 3);
    check("a_wr_csb_cycles", csb_low_cnt - c0, 1);
    check("a_wr_addr0", last_addr, 4);
    check("a_wr_wmask0", last_wmask, 4'hF);
    check("a_wr_web0", last_web, 0);
    check("a_wr_dout0", last_dout, 32'hDEAD_BEEF);
    xfer(0, 0, BASE + 32'h10, 32'h0, 4'h0, lat);
    check("a_rd_lat", lat, 3);
    check("a_rd_web0", last_web, 1);
    check("a_rd_wmask0", last_wmask, 0);
    check("a_dat_hold", a_rdat, 32'hDEAD_BEEF);

    // B partial-word write over a known word.
    xfer(1, 1, BASE + 32'h3FC, 32'hAAAA_AAAA, 4'hF, lat);
    xfer(1, 1, BASE + 32'h3FC, 32'h1234_5678, 4'b0011, lat);
    check("b_part_wmask0", last_wmask, 4'b0011);
    check("b_part_addr0", last_addr, 8'hFF);
    xfer(1, 0, BASE + 32'h3FC, 32'h0, 4'h0, lat);
    check("b_part_rdata", b_rdat, 32'hAAAA_5678);

    // A streams back-to-back; B asks once and is served at the next IDLE.
    fork
      begin
        xfer(0, 0, BASE + 32'h20, 32'h0, 4'h0, lat_a1);
        xfer(0, 0, BASE + 32'h24, 32'h0, 4'h0, lat_a2);
        xfer(0, 0, BASE + 32'h28, 32'h0, 4'h0, lat_a3);
      end
      begin
        @(posedge clk);
        #1;
        xfer(1, 0, BASE + 32'h210, 32'h0, 4'h0, lat_b);
      end
    join
    check("stream_b_lat", lat_b, 6);
    check("stream_b_within_8", 32'(lat_b <= 8), 1);
    check("stream_a2_lat", lat_a2, 7);
    check("stream_a3_lat", lat_a3, 3);

    // Requests that must not reach the RAM.
    oow_adr[0] = 32'h3100_0000;
    oow_adr[1] = BASE + 32'h400;
    oow_adr[2] = BASE - 32'h4;
    oow_adr[3] = BASE + 32'h30;
    for (int k = 0; k < 4; k++) begin
      c0 = csb_low_cnt;
      a_adr = oow_adr[k]; a_we = 1'b0; a_sel = 4'hF;
      a_cyc = (k != 3);
      a_stb = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      a_cyc = 1'b0; a_stb = 1'b0;
      check("no_hit_no_csb", csb_low_cnt - c0, 0);
    end

    // Write aborted in CAPT still lands; no ack; FSM idle at cycle 4.
    c0 = csb_low_cnt;
    model[8] = 32'hCAFE_F00D;
    a_we = 1'b1; a_sel = 4'hF; a_adr = BASE + 32'h20; a_wdat = 32'hCAFE_F00D;
    a_cyc = 1'b1; a_stb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a_cyc = 1'b0; a_stb = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_no_ack", a_ack, 0);
    xfer(0, 0, BASE + 32'h20, 32'h0, 4'h0, lat);
    check("abort_idle_at_4", lat, 4);
    check("abort_csb_cycles", csb_low_cnt - c0, 2);

    // Asynchronous reset during CMD; the pending B read then completes.
    fork
      xfer(1, 0, BASE + 32'h204, 32'h1111_2222, 4'h0, lat_b);
      begin
        @(posedge clk);
        #2;
        check("pre_reset_in_cmd", ram_csb0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_csb0", ram_csb0, 1);
        check("mid_rst_web0", ram_web0, 1);
        check("mid_rst_wmask0", ram_wmask0, 0);
        check("mid_rst_addr0", ram_addr0, 0);
        check("mid_rst_dout0", ram_dout0, 0);
        check("mid_rst_acks", {a_ack, b_ack}, 0);
        check("mid_rst_a_dat", a_rdat, 0);
        check("mid_rst_b_dat", b_rdat, 0);
        #13 rst_n = 1'b1;
      end
    join
    check("post_reset_b_lat_gt3", 32'(lat_b > 3), 1);

    // Random concurrent traffic on disjoint halves of the RAM.
    fork
      for (int n = 0; n < 150; n++) begin
        int l;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        xfer(0, 1'($urandom), BASE | (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3)),
             $urandom, 4'($urandom), l);
        check("a_rand_lat", 32'(l >= 3 && l <= 7), 1);
      end
      for (int n = 0; n < 150; n++) begin
        int l;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        xfer(1, 1'($urandom), BASE | (32'($urandom_range(128, 255)) << 2) | 32'($urandom_range(0, 3)),
             $urandom, 4'($urandom), l);
        check("b_rand_lat", 32'(l >= 3 && l <= 7), 1);
      end
    join

    repeat (5) @(posedge clk);
    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
